// File: rtl/interface_movimento_pkg.sv
// interface_movimento: shared types and constants.
// Direction codes, FSM states, timing defaults.
package interface_movimento_pkg;

  typedef enum logic [1:0] {
    CIMA     = 2'b00,
    BAIXO    = 2'b01,
    ESQUERDA = 2'b10,
    DIREITA  = 2'b11
  } direcao_t;

  typedef enum logic [2:0] {
    OCIOSO   = 3'd0,
    PULSO    = 3'd1,
    ATRASO   = 3'd2,
    REPETE   = 3'd3,
    BLOQUEIO = 3'd4
  } estado_t;

  localparam int DEBOUNCE_PADRAO = 50000;
  localparam int ATRASO_PADRAO   = 25000000;
  localparam int PERIODO_PADRAO  = 10000000;

  localparam int DEBOUNCE_SIM = 4;
  localparam int ATRASO_SIM   = 10;
  localparam int PERIODO_SIM  = 5;

  localparam int TIMER_W = 25;

  function automatic logic [3:0] mascara(
    input direcao_t d
  );
    return 4'b0001 << d;
  endfunction

  function automatic direcao_t codifica(
    input logic [3:0] b
  );
    codifica = CIMA;
    unique case (1'b1)
      b[0]:    codifica = CIMA;
      b[1]:    codifica = BAIXO;
      b[2]:    codifica = ESQUERDA;
      b[3]:    codifica = DIREITA;
      default: codifica = CIMA;
    endcase
  endfunction

endpackage

// File: rtl/interface_movimento_if.sv
// interface_movimento: button/move bus.
// master drives buttons, slave issues moves.
interface interface_movimento_if;
  logic [3:0] botoes;
  logic       habilita;
  logic       borda_movimento;
  logic [1:0] direcao;
  logic [3:0] botoes_filtrados;
  logic [2:0] db_estado;

  modport master (
    output botoes, habilita,
    input  borda_movimento, direcao,
    input  botoes_filtrados, db_estado
  );

  modport slave (
    input  botoes, habilita,
    output borda_movimento, direcao,
    output botoes_filtrados, db_estado
  );
endinterface

// File: rtl/interface_movimento_filtro_botao.sv
// filtro_botao: 2-FF synchroniser plus
// debouncer for one push-button bit.
module filtro_botao #(
  parameter int DEBOUNCE_CICLOS = 4
) (
  input  logic clock,
  input  logic reset,
  input  logic botao_i,
  output logic filtrado_o
);
  localparam int CW = $clog2(DEBOUNCE_CICLOS + 1);
  localparam logic [CW-1:0] CNT_MAX =
    CW'(DEBOUNCE_CICLOS - 1);

  logic          s1_q;
  logic          s2_q;
  logic          filt_q;
  logic [CW-1:0] cnt_q;

  // Sync, then flip only after a full run of disagreeing samples
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      s1_q   <= 1'b0;
      s2_q   <= 1'b0;
      filt_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      s1_q <= botao_i;
      s2_q <= s1_q;
      if (s2_q == filt_q) begin
        cnt_q <= '0;
      end else if (cnt_q == CNT_MAX) begin
        filt_q <= s2_q;
        cnt_q  <= '0;
      end else begin
        cnt_q <= cnt_q + CW'(1);
      end
    end
  end

  assign filtrado_o = filt_q;
endmodule

// File: rtl/interface_movimento.sv
// interface_movimento: direction-button front end
// with debounce, window gating and hold-to-repeat.
module interface_movimento
  import interface_movimento_pkg::*;
#(
  parameter int DEBOUNCE_CICLOS = DEBOUNCE_PADRAO,
  parameter int REPETE_ATRASO   = ATRASO_PADRAO,
  parameter int REPETE_PERIODO  = PERIODO_PADRAO
) (
  input logic                  clock,
  input logic                  reset,
  interface_movimento_if.slave bus
);
  localparam int TW =
    ($clog2(REPETE_ATRASO) > TIMER_W) ?
    $clog2(REPETE_ATRASO) : TIMER_W;
  localparam logic [TW-1:0] CMP_ATRASO =
    TW'(REPETE_ATRASO - 1);
  localparam logic [TW-1:0] CMP_PERIODO =
    TW'(REPETE_PERIODO - 1);

  logic [3:0]    filt;
  logic          valido;
  logic [TW-1:0] cmp;

  estado_t       estado_q;
  direcao_t      dir_q;
  logic          borda_q;
  logic          repete_q;
  logic [TW-1:0] timer_q;

  for (genvar i = 0; i < 4; i++) begin : g_filtro
    filtro_botao #(
      .DEBOUNCE_CICLOS(DEBOUNCE_CICLOS)
    ) u_filtro (
      .clock      (clock),
      .reset      (reset),
      .botao_i    (bus.botoes[i]),
      .filtrado_o (filt[i])
    );
  end

  assign valido = $onehot(filt);
  assign cmp = (estado_q == REPETE) ?
               CMP_PERIODO : CMP_ATRASO;

  // Move FSM with repeat timer; release beats
  // pattern change, which beats expiry.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      estado_q <= OCIOSO;
      dir_q    <= CIMA;
      borda_q  <= 1'b0;
      repete_q <= 1'b0;
      timer_q  <= '0;
    end else begin
      borda_q <= 1'b0;
      unique case (estado_q)
        OCIOSO: begin
          if (bus.habilita && valido) begin
            dir_q    <= codifica(filt);
            estado_q <= PULSO;
            borda_q  <= 1'b1;
            repete_q <= 1'b0;
            timer_q  <= '0;
          end
        end
        PULSO: begin
          estado_q <= repete_q ? REPETE : ATRASO;
          timer_q  <= '0;
        end
        ATRASO, REPETE: begin
          if (filt == 4'b0000) begin
            estado_q <= OCIOSO;
            timer_q  <= '0;
          end else if (filt != mascara(dir_q)) begin
            estado_q <= BLOQUEIO;
            timer_q  <= '0;
          end else if (timer_q == cmp) begin
            if (bus.habilita) begin
              estado_q <= PULSO;
              borda_q  <= 1'b1;
              repete_q <= 1'b1;
              timer_q  <= '0;
            end
          end else begin
            timer_q <= timer_q + TW'(1);
          end
        end
        BLOQUEIO: begin
          if (filt == 4'b0000) begin
            estado_q <= OCIOSO;
            timer_q  <= '0;
          end
        end
        default: begin
          estado_q <= OCIOSO;
          timer_q  <= '0;
        end
      endcase
    end
  end

  // The window may close during the pulse cycle;
  // never present a move outside it.
  assign bus.borda_movimento  = borda_q & bus.habilita;
  assign bus.direcao          = dir_q;
  assign bus.botoes_filtrados = filt;
  assign bus.db_estado        = estado_q;
endmodule

// File: tb/tb_interface_movimento.sv
// tb_interface_movimento: scoreboard bench with
// reduced timing constants.
module tb_interface_movimento;
  import interface_movimento_pkg::*;

  typedef struct {
    int         ciclo;
    logic [1:0] dir;
  } esperado_t;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_erros = 0;
  logic borda_ant = 1'b0;
  esperado_t fila[$];

  interface_movimento_if bus();

  interface_movimento #(
    .DEBOUNCE_CICLOS(DEBOUNCE_SIM),
    .REPETE_ATRASO  (ATRASO_SIM),
    .REPETE_PERIODO (PERIODO_SIM)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic verifica(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] esp
  );
    n_checks++;
    if (obs !== esp) begin
      n_erros++;
      $display("FAIL %s: observed %0d expected %0d",
               tag, obs, esp);
    end
  endtask

  task automatic espera(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic verifica_zero(input string tag);
    verifica({tag, "_borda"}, 32'(bus.borda_movimento), 0);
    verifica({tag, "_dir"}, 32'(bus.direcao), 0);
    verifica({tag, "_filt"}, 32'(bus.botoes_filtrados), 0);
    verifica({tag, "_estado"}, 32'(bus.db_estado), 0);
  endtask

  // Pulse monitor: pops the scoreboard on every move
  always begin
    @(negedge clock);
    #1;
    if (!reset && bus.borda_movimento) begin
      verifica("borda_habilita", 32'(bus.habilita), 1);
      verifica("borda_consecutiva", 32'(borda_ant), 0);
      if (fila.size() == 0) begin
        verifica("pulso_inesperado", 0, 1);
      end else begin
        esperado_t e;
        e = fila.pop_front();
        verifica("pulso_ciclo", cyc, e.ciclo);
        verifica("pulso_dir", 32'(bus.direcao),
                 32'(e.dir));
      end
    end
    borda_ant = bus.borda_movimento;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int c;
    int r;
    bus.botoes   = 4'b0000;
    bus.habilita = 1'b1;

    @(negedge clock);
    verifica_zero("reset");
    espera(2);
    reset = 1'b0;
    espera(3);

    // short glitch-like press never reaches the filter
    bus.botoes = 4'b0100;
    espera(3);
    bus.botoes = 4'b0000;
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      verifica("filtro_curto",
               32'(bus.botoes_filtrados), 0);
    end

    // single move to the left
    c = cyc;
    fila.push_back('{c + 7, 2'b10});
    bus.botoes = 4'b0100;
    espera(7);
    verifica("filtrado_esq",
             32'(bus.botoes_filtrados), 32'h4);
    espera(1);
    bus.botoes = 4'b0000;
    espera(12);
    verifica("simples_estado", 32'(bus.db_estado), 0);
    verifica("simples_fila", fila.size(), 0);

    // hold-to-repeat upwards
    c = cyc;
    fila.push_back('{c + 7, 2'b00});
    for (int k = c + 18; k < c + 47; k += 6)
      fila.push_back('{k, 2'b00});
    bus.botoes = 4'b0001;
    espera(40);
    bus.botoes = 4'b0000;
    espera(12);
    verifica("repete_estado", 32'(bus.db_estado), 0);
    verifica("repete_fila", fila.size(), 0);

    // window closed while pressing right
    bus.habilita = 1'b0;
    bus.botoes   = 4'b1000;
    espera(20);
    verifica("janela_estado", 32'(bus.db_estado), 0);
    verifica("janela_filt",
             32'(bus.botoes_filtrados), 32'h8);
    fila.push_back('{cyc + 1, 2'b11});
    bus.habilita = 1'b1;
    espera(1);
    bus.botoes = 4'b0000;
    espera(12);
    verifica("janela_fila", fila.size(), 0);
    verifica("janela_fim", 32'(bus.db_estado), 0);

    // two buttons together never move
    bus.botoes = 4'b0011;
    espera(15);
    verifica("multi_estado", 32'(bus.db_estado), 0);
    bus.botoes = 4'b0000;
    espera(10);

    // second button added during the first delay
    c = cyc;
    fila.push_back('{c + 7, 2'b01});
    bus.botoes = 4'b0010;
    espera(9);
    bus.botoes = 4'b0110;
    espera(9);
    verifica("bloqueio_estado", 32'(bus.db_estado), 4);
    espera(20);
    verifica("bloqueio_mantem", 32'(bus.db_estado), 4);
    bus.botoes = 4'b0000;
    espera(10);
    verifica("bloqueio_sai", 32'(bus.db_estado), 0);
    verifica("bloqueio_fila", fila.size(), 0);

    // asynchronous reset in the middle of a repeat
    c = cyc;
    fila.push_back('{c + 7, 2'b11});
    fila.push_back('{c + 18, 2'b11});
    fila.push_back('{c + 24, 2'b11});
    bus.botoes = 4'b1000;
    espera(26);
    verifica("pre_reset_estado", 32'(bus.db_estado), 3);
    reset = 1'b1;
    #1;
    verifica_zero("reset_async");
    espera(2);
    reset = 1'b0;
    r = cyc;
    fila.push_back('{r + 7, 2'b11});
    espera(8);
    bus.botoes = 4'b0000;
    espera(12);
    verifica("pos_reset_estado", 32'(bus.db_estado), 0);

    espera(5);
    verifica("fila_final", fila.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_erros);
    $finish;
  end
endmodule
